// File: rtl/simon_word_loader_if.sv
// simon_word_loader_if: word-stream input and assembled-load output bundle of the SIMON word loader
interface simon_word_loader_if #(parameter int WW = 16, parameter int NKW = 4);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [WW-1:0]     in_data_i;
  logic              in_mode_i;
  logic              in_last_i;
  logic              in_key_reuse_i;
  logic              valid_o;
  logic              ready_i;
  logic              mode_o;
  logic [2*WW-1:0]   pt_o;
  logic [NKW*WW-1:0] key_o;
  modport master (
    output in_valid_i, in_data_i, in_mode_i, in_last_i, in_key_reuse_i, ready_i,
    input  in_ready_o, valid_o, mode_o, pt_o, key_o
  );
  modport slave (
    input  in_valid_i, in_data_i, in_mode_i, in_last_i, in_key_reuse_i, ready_i,
    output in_ready_o, valid_o, mode_o, pt_o, key_o
  );
endinterface

// File: rtl/simon_word_loader.sv
// simon_word_loader: assembles block and key words into a held load; SIMON_LOADER_KEY_REUSE_EN enables key reuse
module simon_word_loader #(
  parameter int WW  = 16,
  parameter int NKW = 4
) (
  input  logic clk,
  input  logic srst_n,
  output logic active_o,
  output logic err_o,
  simon_word_loader_if.slave b
);
  localparam int CW = $clog2(NKW + 3);
  typedef enum logic {S_FILL, S_HOLD} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2*WW-1:0] pt;
  logic [NKW*WW-1:0] key;
  logic mode, err, key_stored, reuse_r;
  logic beat, at_end, done, frame_err, reuse_ok, reuse_bad;
  assign beat = b.in_valid_i & b.in_ready_o;
`ifdef SIMON_LOADER_KEY_REUSE_EN
  // reuse is decided on beat 0 and then remembered for the rest of the load
  assign reuse_ok  = (cnt == '0) ? b.in_key_reuse_i & key_stored : reuse_r;
  assign reuse_bad = beat & (cnt == '0) & b.in_key_reuse_i & ~key_stored;
`else
  assign reuse_ok  = 1'b0;
  assign reuse_bad = 1'b0;
  logic unused_reuse;
  assign unused_reuse = &{1'b0, b.in_key_reuse_i, reuse_r, key_stored};
`endif
  always_comb begin
    at_end    = cnt == (reuse_ok ? CW'(1) : CW'(NKW + 1));
    done      = beat & at_end & b.in_last_i;
    frame_err = reuse_bad | (beat & (at_end ^ b.in_last_i));
    state_n   = (state == S_FILL) ? (done ? S_HOLD : S_FILL) : (b.ready_i ? S_FILL : S_HOLD);
    cnt_n     = (done | frame_err) ? '0 : cnt + CW'(beat);
  end
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state      <= S_FILL;
      cnt        <= '0;
      pt         <= '0;
      key        <= '0;
      mode       <= 1'b0;
      err        <= 1'b0;
      key_stored <= 1'b0;
      reuse_r    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      err   <= frame_err;
      if (beat & ~reuse_bad) begin
        if (cnt == '0) begin
          pt[2*WW-1:WW] <= b.in_data_i;
          mode          <= b.in_mode_i;
          reuse_r       <= reuse_ok;
        end
        if (cnt == CW'(1)) pt[WW-1:0] <= b.in_data_i;
        // key words arrive most significant first, starting at beat 2
        for (int i = 0; i < NKW; i++)
          if (cnt == CW'(NKW + 1 - i)) key[i*WW +: WW] <= b.in_data_i;
      end
      if (frame_err) key_stored <= 1'b0;
      else if (done) key_stored <= 1'b1;
    end
  end
  assign b.in_ready_o = srst_n & (state == S_FILL);
  assign b.valid_o    = state == S_HOLD;
  assign b.mode_o     = mode;
  assign b.pt_o       = pt;
  assign b.key_o      = key;
  assign err_o        = err;
  assign active_o     = (state == S_HOLD) | (cnt != '0);
endmodule
